// File: rtl/pipe_mem_if.sv
// pipe_mem_if: request/response bus between a pipeline and its memory responder
interface pipe_mem_if;
    logic        req_valid;
    logic        req_we;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/pipe_mem_responder.sv
// pipe_mem_responder: 16-word memory answering one request at a time after WAIT_CYCLES wait states
module pipe_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = 16
) (
    input logic       clk,
    input logic       rst,
    pipe_mem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [5:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        accept, enter_rsp, cur_we;
    logic [5:0]  cur_addr;
    logic [31:0] cur_wdata;
    assign bus.req_ready = state_q == IDLE;
    assign bus.rsp_valid = state_q == RESP;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    // Next state, wait countdown, and the response computed from the request being completed
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = state_q == IDLE && bus.req_valid;
        cur_we    = state_q == IDLE ? bus.req_we : we_q;
        cur_addr  = state_q == IDLE ? bus.req_addr : addr_q;
        cur_wdata = state_q == IDLE ? bus.req_wdata : wdata_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                state_d = WC == 4'd0 ? RESP : WAIT;
                cnt_d   = WC;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q == 4'd1 ? RESP : WAIT;
            end
            RESP: state_d = bus.rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        enter_rsp = state_d == RESP && state_q != RESP;
        err_d     = cur_addr[5:4] != 2'b00;
        rdata_d   = (cur_we || err_d) ? 32'd0 : mem_q[cur_addr[3:0]];
    end
    // Control state, latched request and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (enter_rsp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end
    // Storage array; an in-range store lands as the response is produced
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (enter_rsp && cur_we && !err_d) begin
            mem_q[cur_addr[3:0]] <= cur_wdata;
        end
    end
endmodule

// File: tb/tb_pipe_mem_responder.sv
// tb_pipe_mem_responder: directed and random requests against a reference memory model
module tb_pipe_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic        rdy = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        obs_valid, obs_ready, obs_err;
    logic [31:0] obs_rdata;
    logic [31:0] ref_mem [2][16];
    int          total = 0;
    int          bad = 0;
    always #5 clk = ~clk;
    pipe_mem_if m ();
    pipe_mem_if z ();
    assign m.req_valid = req_valid & ~sel;
    assign z.req_valid = req_valid & sel;
    assign m.req_we    = req_we;
    assign z.req_we    = req_we;
    assign m.req_addr  = req_addr;
    assign z.req_addr  = req_addr;
    assign m.req_wdata = req_wdata;
    assign z.req_wdata = req_wdata;
    assign m.rsp_ready = rdy & ~sel;
    assign z.rsp_ready = rdy & sel;
    assign obs_valid = sel ? z.rsp_valid : m.rsp_valid;
    assign obs_ready = sel ? z.req_ready : m.req_ready;
    assign obs_err   = sel ? z.rsp_err   : m.rsp_err;
    assign obs_rdata = sel ? z.rsp_rdata : m.rsp_rdata;
    pipe_mem_responder #(.WAIT_CYCLES(2)) dut  (.clk(clk), .rst(rst), .bus(m));
    pipe_mem_responder #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(z));
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic clear_ref();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++) ref_mem[s][i] = '0;
    endtask
    task automatic scramble();
        req_valid = 1'($urandom);
        req_we    = 1'($urandom);
        req_addr  = 6'($urandom);
        req_wdata = $urandom;
    endtask
    task automatic txn(input logic s, input logic we, input logic [5:0] a, input logic [31:0] wd, input int hold);
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          w;
        w   = s ? 0 : 2;
        err = a[5:4] != 2'b00;
        rd  = (we || err) ? 32'd0 : ref_mem[s][a[3:0]];
        if (we && !err) ref_mem[s][a[3:0]] = wd;
        sel = s;
        rdy = 1'b0;
        #1;
        chk("req_ready_idle", 64'(obs_ready), 64'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!obs_valid) chk("ready_low_wait", 64'(obs_ready), 64'd0);
            scramble();
        end while (!obs_valid && lat < 20);
        chk("latency", 64'(lat), 64'(w + 1));
        chk("rsp", 64'({obs_ready, obs_err, obs_rdata}), 64'({1'b0, err, rd}));
        repeat (hold) begin
            @(negedge clk);
            scramble();
            chk("hold", 64'({obs_valid, obs_ready, obs_err, obs_rdata}), 64'({1'b1, 1'b0, err, rd}));
        end
        rdy = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rdy = 1'b0;
        chk("done", 64'({obs_valid, obs_ready}), 64'd1);
        @(negedge clk);
        chk("idle", 64'({obs_valid, obs_ready}), 64'd1);
    endtask
    initial begin
        clear_ref();
        #1 rst = 1'b1;
        #2;
        chk("reset_main", 64'({obs_ready, obs_valid, obs_err, obs_rdata}), 64'({1'b1, 1'b0, 1'b0, 32'd0}));
        sel = 1'b1;
        #1;
        chk("reset_w0", 64'({obs_ready, obs_valid, obs_err, obs_rdata}), 64'({1'b1, 1'b0, 1'b0, 32'd0}));
        sel = 1'b0;
        @(negedge clk) rst = 1'b0;
        txn(1'b0, 1'b0, 6'd5, 32'd0, 0);
        txn(1'b0, 1'b1, 6'd3, 32'hDEADBEEF, 0);
        txn(1'b0, 1'b0, 6'd3, 32'd0, 0);
        txn(1'b0, 1'b1, 6'h20, 32'h55AA55AA, 0);
        txn(1'b0, 1'b0, 6'd0, 32'd0, 0);
        txn(1'b0, 1'b0, 6'd3, 32'd0, 4);
        sel       = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 6'd7;
        req_wdata = 32'h1234;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wait_ready_low", 64'(obs_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", 64'({obs_ready, obs_valid, obs_err, obs_rdata}), 64'({1'b1, 1'b0, 1'b0, 32'd0}));
        clear_ref();
        @(negedge clk) rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("no_rsp_after_rst", 64'(obs_valid), 64'd0);
        end
        txn(1'b0, 1'b0, 6'd7, 32'd0, 0);
        txn(1'b1, 1'b0, 6'd1, 32'd0, 0);
        txn(1'b1, 1'b1, 6'd1, 32'hCAFEF00D, 1);
        txn(1'b1, 1'b0, 6'd1, 32'd0, 2);
        txn(1'b1, 1'b1, 6'h3F, 32'h11111111, 0);
        for (int k = 0; k < 40; k++) begin
            logic [5:0] a;
            a = ($urandom_range(0, 7) == 0) ? 6'($urandom) : {2'b00, 4'($urandom)};
            txn(1'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 3));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
